// File: rtl/bank_axi3_mem_slave.sv
// AXI3 slave memory responder backing a line-granular SRAM array.
// Independent read and write engines, one outstanding burst per direction.
module bank_axi3_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 6,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    slv_axi3_arvalid_i,
  output logic                    slv_axi3_arready_o,
  input  logic [ID_WIDTH-1:0]     slv_axi3_arid_i,
  input  logic [ADDR_WIDTH-1:0]   slv_axi3_araddr_i,
  input  logic [3:0]              slv_axi3_arlen_i,
  input  logic [2:0]              slv_axi3_arsize_i,
  input  logic [1:0]              slv_axi3_arburst_i,
  output logic                    slv_axi3_rvalid_o,
  input  logic                    slv_axi3_rready_i,
  output logic [ID_WIDTH-1:0]     slv_axi3_rid_o,
  output logic [DATA_WIDTH-1:0]   slv_axi3_rdata_o,
  output logic [1:0]              slv_axi3_rresp_o,
  output logic                    slv_axi3_rlast_o,
  input  logic                    slv_axi3_awvalid_i,
  output logic                    slv_axi3_awready_o,
  input  logic [ID_WIDTH-1:0]     slv_axi3_awid_i,
  input  logic [ADDR_WIDTH-1:0]   slv_axi3_awaddr_i,
  input  logic [3:0]              slv_axi3_awlen_i,
  input  logic [2:0]              slv_axi3_awsize_i,
  input  logic [1:0]              slv_axi3_awburst_i,
  input  logic                    slv_axi3_wvalid_i,
  output logic                    slv_axi3_wready_o,
  input  logic [ID_WIDTH-1:0]     slv_axi3_wid_i,
  input  logic [DATA_WIDTH-1:0]   slv_axi3_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] slv_axi3_wstrb_i,
  input  logic                    slv_axi3_wlast_i,
  output logic                    slv_axi3_bvalid_o,
  input  logic                    slv_axi3_bready_i,
  output logic [ID_WIDTH-1:0]     slv_axi3_bid_o,
  output logic [1:0]              slv_axi3_bresp_o
);

  localparam int LINE_W = ADDR_WIDTH - 5;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_WAIT = 2'd1, RD_DATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_DATA = 2'd1, WR_RESP = 2'd2} wr_state_t;

  // Any line bit above the array index range means the beat falls off the array.
  function automatic logic line_oob(input logic [LINE_W-1:0] line);
    line_oob = (line >> DEPTH_LOG2) != {LINE_W{1'b0}};
  endfunction

  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    burst_bad = (burst != 2'b01) || (size != 3'b101);
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [2**DEPTH_LOG2];

  rd_state_t             rd_state_r, rd_state_s;
  logic [ID_WIDTH-1:0]   rd_id_r;
  logic [LINE_W-1:0]     rd_line_r, rd_ld_line_s;
  logic [3:0]            rd_len_r, rd_cnt_r, rd_ld_len_s, rd_ld_cnt_s;
  logic                  rd_berr_r, rd_ld_berr_s, rd_ld_err_s, rd_load_s;
  logic [WAIT_W-1:0]     rd_wait_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [1:0]            rresp_r;
  logic                  rlast_r, ar_hs_s, r_hs_s;

  wr_state_t             wr_state_r, wr_state_s;
  logic [ID_WIDTH-1:0]   wr_id_r;
  logic [LINE_W-1:0]     wr_line_r;
  logic [3:0]            wr_len_r, wr_cnt_r;
  logic                  wr_berr_r, wr_err_r, wr_last_s, wr_beat_err_s;
  logic [1:0]            bresp_r;
  logic                  aw_hs_s, w_hs_s, b_hs_s;
  logic                  unused_addr_bits_s;

  assign unused_addr_bits_s = ^{slv_axi3_araddr_i[4:0], slv_axi3_awaddr_i[4:0]};

  assign ar_hs_s     = slv_axi3_arvalid_i && (rd_state_r == RD_IDLE);
  assign r_hs_s      = slv_axi3_rready_i && (rd_state_r == RD_DATA);
  assign rd_ld_err_s = rd_ld_berr_s || line_oob(rd_ld_line_s);

  // Read next state, and which line/count the rdata register loads this cycle.
  always_comb begin
    rd_state_s   = rd_state_r;
    rd_load_s    = 1'b0;
    rd_ld_line_s = rd_line_r;
    rd_ld_cnt_s  = rd_cnt_r;
    rd_ld_len_s  = rd_len_r;
    rd_ld_berr_s = rd_berr_r;
    case (rd_state_r)
      RD_IDLE: begin
        if (ar_hs_s) begin
          rd_ld_line_s = slv_axi3_araddr_i[ADDR_WIDTH-1:5];
          rd_ld_cnt_s  = 4'd0;
          rd_ld_len_s  = slv_axi3_arlen_i;
          rd_ld_berr_s = burst_bad(slv_axi3_arburst_i, slv_axi3_arsize_i);
          if (RD_LAT == 0) begin
            rd_state_s = RD_DATA;
            rd_load_s  = 1'b1;
          end else begin
            rd_state_s = RD_WAIT;
          end
        end else begin
          rd_state_s = RD_IDLE;
        end
      end
      RD_WAIT: begin
        if (rd_wait_r == WAIT_LAST) begin
          rd_state_s = RD_DATA;
          rd_load_s  = 1'b1;
        end else begin
          rd_state_s = RD_WAIT;
        end
      end
      RD_DATA: begin
        if (r_hs_s) begin
          if (rlast_r) begin
            rd_state_s = RD_IDLE;
          end else begin
            rd_state_s   = RD_DATA;
            rd_load_s    = 1'b1;
            rd_ld_line_s = rd_line_r + LINE_W'(1);
            rd_ld_cnt_s  = rd_cnt_r + 4'd1;
          end
        end else begin
          rd_state_s = RD_DATA;
        end
      end
      default: rd_state_s = RD_IDLE;
    endcase
  end

  // Read engine state and the registered R channel; a load samples the pre-write array value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_state_r <= RD_IDLE;
      rd_id_r    <= {ID_WIDTH{1'b0}};
      rd_line_r  <= {LINE_W{1'b0}};
      rd_len_r   <= 4'd0;
      rd_cnt_r   <= 4'd0;
      rd_berr_r  <= 1'b0;
      rd_wait_r  <= {WAIT_W{1'b0}};
      rdata_r    <= {DATA_WIDTH{1'b0}};
      rresp_r    <= 2'b00;
      rlast_r    <= 1'b0;
    end else begin
      rd_state_r <= rd_state_s;
      rd_line_r  <= rd_ld_line_s;
      rd_cnt_r   <= rd_ld_cnt_s;
      rd_len_r   <= rd_ld_len_s;
      rd_berr_r  <= rd_ld_berr_s;
      if (ar_hs_s) begin
        rd_id_r <= slv_axi3_arid_i;
      end
      if (rd_state_r == RD_WAIT) begin
        rd_wait_r <= rd_wait_r + WAIT_W'(1);
      end else begin
        rd_wait_r <= {WAIT_W{1'b0}};
      end
      if (rd_load_s) begin
        rdata_r <= rd_ld_err_s ? {DATA_WIDTH{1'b0}} : mem_r[rd_ld_line_s[DEPTH_LOG2-1:0]];
        rresp_r <= rd_ld_err_s ? 2'b10 : 2'b00;
        rlast_r <= (rd_ld_cnt_s == rd_ld_len_s);
      end else if (r_hs_s && rlast_r) begin
        rresp_r <= 2'b00;
        rlast_r <= 1'b0;
      end
    end
  end

  assign aw_hs_s       = slv_axi3_awvalid_i && (wr_state_r == WR_IDLE);
  assign w_hs_s        = slv_axi3_wvalid_i && (wr_state_r == WR_DATA);
  assign b_hs_s        = slv_axi3_bready_i && (wr_state_r == WR_RESP);
  assign wr_last_s     = (wr_cnt_r == wr_len_r);
  assign wr_beat_err_s = wr_berr_r || line_oob(wr_line_r) ||
                         (slv_axi3_wid_i != wr_id_r) || (slv_axi3_wlast_i != wr_last_s);

  // Write next state; the burst length, not wlast, decides where it ends.
  always_comb begin
    wr_state_s = wr_state_r;
    case (wr_state_r)
      WR_IDLE: if (aw_hs_s) wr_state_s = WR_DATA; else wr_state_s = WR_IDLE;
      WR_DATA: if (w_hs_s && wr_last_s) wr_state_s = WR_RESP; else wr_state_s = WR_DATA;
      WR_RESP: if (b_hs_s) wr_state_s = WR_IDLE; else wr_state_s = WR_RESP;
      default: wr_state_s = WR_IDLE;
    endcase
  end

  // Write engine state, beat tracking and sticky error for the B response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_state_r <= WR_IDLE;
      wr_id_r    <= {ID_WIDTH{1'b0}};
      wr_line_r  <= {LINE_W{1'b0}};
      wr_len_r   <= 4'd0;
      wr_cnt_r   <= 4'd0;
      wr_berr_r  <= 1'b0;
      wr_err_r   <= 1'b0;
      bresp_r    <= 2'b00;
    end else begin
      wr_state_r <= wr_state_s;
      if (aw_hs_s) begin
        wr_id_r   <= slv_axi3_awid_i;
        wr_line_r <= slv_axi3_awaddr_i[ADDR_WIDTH-1:5];
        wr_len_r  <= slv_axi3_awlen_i;
        wr_cnt_r  <= 4'd0;
        wr_berr_r <= burst_bad(slv_axi3_awburst_i, slv_axi3_awsize_i);
        wr_err_r  <= 1'b0;
      end else if (w_hs_s) begin
        wr_line_r <= wr_line_r + LINE_W'(1);
        wr_cnt_r  <= wr_cnt_r + 4'd1;
        wr_err_r  <= wr_err_r || wr_beat_err_s;
        if (wr_last_s) begin
          bresp_r <= (wr_err_r || wr_beat_err_s) ? 2'b10 : 2'b00;
        end
      end else if (b_hs_s) begin
        bresp_r <= 2'b00;
      end
    end
  end

  // Byte-masked array write; error beats leave the array untouched.
  always_ff @(posedge clk_i) begin
    if (w_hs_s && !wr_beat_err_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (slv_axi3_wstrb_i[b]) begin
          mem_r[wr_line_r[DEPTH_LOG2-1:0]][8*b +: 8] <= slv_axi3_wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign slv_axi3_arready_o = (rd_state_r == RD_IDLE);
  assign slv_axi3_rvalid_o  = (rd_state_r == RD_DATA);
  assign slv_axi3_rid_o     = rd_id_r;
  assign slv_axi3_rdata_o   = rdata_r;
  assign slv_axi3_rresp_o   = rresp_r;
  assign slv_axi3_rlast_o   = rlast_r;
  assign slv_axi3_awready_o = (wr_state_r == WR_IDLE);
  assign slv_axi3_wready_o  = (wr_state_r == WR_DATA);
  assign slv_axi3_bvalid_o  = (wr_state_r == WR_RESP);
  assign slv_axi3_bid_o     = wr_id_r;
  assign slv_axi3_bresp_o   = bresp_r;

endmodule

// File: tb/tb_bank_axi3_mem_slave.sv
// Randomized bench for bank_axi3_mem_slave against a line-array reference model.
module tb_bank_axi3_mem_slave;

  localparam int RD_LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         arvalid = 1'b0, arready;
  logic [5:0]   arid = 6'd0;
  logic [31:0]  araddr = 32'd0;
  logic [3:0]   arlen = 4'd0;
  logic [2:0]   arsize = 3'd0;
  logic [1:0]   arburst = 2'd0;
  logic         rvalid, rready = 1'b0;
  logic [5:0]   rid;
  logic [255:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         awvalid = 1'b0, awready;
  logic [5:0]   awid = 6'd0;
  logic [31:0]  awaddr = 32'd0;
  logic [3:0]   awlen = 4'd0;
  logic [2:0]   awsize = 3'd0;
  logic [1:0]   awburst = 2'd0;
  logic         wvalid = 1'b0, wready;
  logic [5:0]   wid = 6'd0;
  logic [255:0] wdata = 256'd0;
  logic [31:0]  wstrb = 32'd0;
  logic         wlast = 1'b0;
  logic         bvalid, bready = 1'b0;
  logic [5:0]   bid;
  logic [1:0]   bresp;

  logic [255:0] mdl [1024];
  int total_cnt = 0;
  int bad_cnt = 0;

  always #5 clk = ~clk;

  bank_axi3_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(256), .ID_WIDTH(6),
                        .DEPTH_LOG2(10), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .slv_axi3_arvalid_i(arvalid), .slv_axi3_arready_o(arready),
    .slv_axi3_arid_i(arid), .slv_axi3_araddr_i(araddr), .slv_axi3_arlen_i(arlen),
    .slv_axi3_arsize_i(arsize), .slv_axi3_arburst_i(arburst),
    .slv_axi3_rvalid_o(rvalid), .slv_axi3_rready_i(rready),
    .slv_axi3_rid_o(rid), .slv_axi3_rdata_o(rdata), .slv_axi3_rresp_o(rresp),
    .slv_axi3_rlast_o(rlast),
    .slv_axi3_awvalid_i(awvalid), .slv_axi3_awready_o(awready),
    .slv_axi3_awid_i(awid), .slv_axi3_awaddr_i(awaddr), .slv_axi3_awlen_i(awlen),
    .slv_axi3_awsize_i(awsize), .slv_axi3_awburst_i(awburst),
    .slv_axi3_wvalid_i(wvalid), .slv_axi3_wready_o(wready),
    .slv_axi3_wid_i(wid), .slv_axi3_wdata_i(wdata), .slv_axi3_wstrb_i(wstrb),
    .slv_axi3_wlast_i(wlast),
    .slv_axi3_bvalid_o(bvalid), .slv_axi3_bready_i(bready),
    .slv_axi3_bid_o(bid), .slv_axi3_bresp_o(bresp)
  );

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] want);
    total_cnt++;
    if (obs !== want) begin
      bad_cnt++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic sig_of(input int sel);
    case (sel)
      0: return arready;
      1: return awready;
      2: return wready;
      3: return bvalid;
      default: return rvalid;
    endcase
  endfunction

  // Waits (sampling on negedges) until the selected signal is high, bounded.
  task automatic wait_hi(input int sel, input string tag);
    int n = 0;
    forever begin
      @(negedge clk);
      if (sig_of(sel)) break;
      n++;
      if (n >= 200) begin
        check_eq(tag, 256'd0, 256'd1);
        break;
      end
    end
  endtask

  task automatic send_beat(input logic [5:0] w_id, input logic [255:0] d,
                           input logic [31:0] s, input logic wl);
    wid = w_id; wdata = d; wstrb = s; wlast = wl; wvalid = 1'b1;
    wait_hi(2, "w_timeout");
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic axi_write(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size,
                           input int bad_kind, input int bad_beat, input int strb_mode);
    bit berr, err, beat_err, bad;
    int unsigned line;
    logic [255:0] d;
    logic [31:0] s;
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    wait_hi(1, "aw_timeout");
    @(posedge clk); #1;
    awvalid = 1'b0;
    berr = (burst != 2'b01) || (size != 3'b101);
    err = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      d = rand256();
      s = (strb_mode == 0) ? 32'hFFFF_FFFF : (strb_mode == 1) ? $urandom : 32'h0000_000F;
      bad = (bad_kind != 0) && (b == bad_beat);
      send_beat((bad && bad_kind == 1) ? (id ^ 6'h01) : id, d, s,
                (b == int'(len)) ^ (bad && bad_kind == 2));
      line = (addr >> 5) + b;
      beat_err = berr || (line >= 1024) || bad;
      if (!beat_err) begin
        for (int k = 0; k < 32; k++) if (s[k]) mdl[line][8*k +: 8] = d[8*k +: 8];
      end
      err = err || beat_err;
    end
    wait_hi(3, "b_timeout");
    check_eq("bid", bid, id);
    check_eq("bresp", bresp, err ? 2'b10 : 2'b00);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  function automatic logic pick_rready(input int mode, input int k);
    case (mode)
      0: return ($urandom_range(0, 2) != 0);
      1: return ((k % 4) == 0) || ((k % 4) == 3);
      default: return 1'b1;
    endcase
  endfunction

  task automatic axi_read(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int mode);
    logic [255:0] exp_d [16];
    logic [1:0] exp_r [16];
    int unsigned line;
    bit berr, first;
    int i, n, k;
    berr = (burst != 2'b01) || (size != 3'b101);
    for (int b = 0; b <= int'(len); b++) begin
      line = (addr >> 5) + b;
      if (berr || line >= 1024) begin
        exp_d[b] = 256'd0; exp_r[b] = 2'b10;
      end else begin
        exp_d[b] = mdl[line]; exp_r[b] = 2'b00;
      end
    end
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    wait_hi(0, "ar_timeout");
    @(posedge clk); #1;
    arvalid = 1'b0;
    i = 0; n = 0; k = 0; first = 1'b1;
    rready = pick_rready(mode, k);
    while (i <= int'(len) && n < 300) begin
      @(negedge clk);
      n++;
      if (rvalid) begin
        if (first) begin
          check_eq("r_latency", n, RD_LAT + 1);
          first = 1'b0;
        end
        check_eq("rid", rid, id);
        check_eq("rdata", rdata, exp_d[i]);
        check_eq("rresp", rresp, exp_r[i]);
        check_eq("rlast", rlast, i == int'(len));
        if (rready) i++;
      end
      @(posedge clk); #1;
      k++;
      rready = pick_rready(mode, k);
    end
    if (i <= int'(len)) check_eq("r_timeout", 256'd0, 256'd1);
    rready = 1'b0;
    @(negedge clk);
    check_eq("arready_back", arready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d;
    int unsigned line;
    logic [3:0] len;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rvalid", rvalid, 1'b0);
    check_eq("rst_bvalid", bvalid, 1'b0);
    check_eq("rst_wready", wready, 1'b0);
    check_eq("rst_rlast", rlast, 1'b0);
    check_eq("rst_rresp", rresp, 2'b00);
    check_eq("rst_rid", rid, 6'd0);
    check_eq("rst_rdata", rdata, 256'd0);
    check_eq("rst_bid", bid, 6'd0);
    check_eq("rst_bresp", bresp, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arready_after_rst", arready, 1'b1);
    check_eq("awready_after_rst", awready, 1'b1);

    // Known contents for every line the run touches.
    for (int b = 0; b < 4; b++) axi_write(6'd1, 32'(b * 16 * 32), 4'd15, 2'b01, 3'b101, 0, 0, 0);
    axi_write(6'd1, 32'(1008 * 32), 4'd15, 2'b01, 3'b101, 0, 0, 0);

    axi_write(6'd5, 32'h40, 4'd0, 2'b01, 3'b101, 0, 0, 0);
    axi_read(6'd9, 32'h40, 4'd0, 2'b01, 3'b101, 2);

    axi_write(6'd2, 32'h0, 4'd0, 2'b01, 3'b101, 0, 0, 0);
    axi_write(6'd2, 32'h0, 4'd0, 2'b01, 3'b101, 0, 0, 2);
    axi_read(6'd3, 32'h0, 4'd0, 2'b01, 3'b101, 2);

    axi_read(6'd4, 32'h100, 4'd3, 2'b01, 3'b101, 1);

    axi_read(6'd6, 32'h8000_0000, 4'd0, 2'b01, 3'b101, 2);
    axi_read(6'd6, 32'(1022 * 32), 4'd3, 2'b01, 3'b101, 0);
    axi_write(6'd7, 32'h60, 4'd0, 2'b00, 3'b101, 0, 0, 0);
    axi_read(6'd7, 32'h60, 4'd0, 2'b01, 3'b101, 2);
    axi_write(6'd8, 32'h80, 4'd2, 2'b01, 3'b101, 1, 1, 0);
    axi_write(6'd8, 32'hE0, 4'd2, 2'b01, 3'b101, 2, 0, 0);
    axi_read(6'd8, 32'h80, 4'd5, 2'b01, 3'b101, 2);
    axi_write(6'd9, 32'(1021 * 32), 4'd4, 2'b01, 3'b101, 0, 0, 1);
    axi_read(6'd9, 32'(1020 * 32), 4'd5, 2'b01, 3'b101, 0);

    // AR and AW together on line 2; the W beat lands on the rdata load edge.
    fork
      axi_read(6'd10, 32'h40, 4'd0, 2'b01, 3'b101, 2);
      begin
        @(posedge clk); #1;
        awid = 6'd11; awaddr = 32'h40; awlen = 4'd0; awburst = 2'b01; awsize = 3'b101;
        awvalid = 1'b1;
        wait_hi(1, "aw_timeout");
        @(posedge clk); #1;
        awvalid = 1'b0;
        repeat (RD_LAT - 1) @(posedge clk);
        #1;
        d = rand256();
        send_beat(6'd11, d, 32'hFFFF_FFFF, 1'b1);
        mdl[2] = d;
        wait_hi(3, "b_timeout");
        check_eq("conc_bresp", bresp, 2'b00);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
      end
    join
    axi_read(6'd12, 32'h40, 4'd0, 2'b01, 3'b101, 2);

    for (int op = 0; op < 70; op++) begin
      len = 4'($urandom_range(0, 15));
      line = ($urandom_range(0, 3) == 0) ? $urandom_range(1010, 1023) : $urandom_range(0, 48);
      if ($urandom_range(0, 1) == 0) begin
        axi_write(6'($urandom), 32'(line * 32) | 32'($urandom_range(0, 31)), len,
                  ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01,
                  ($urandom_range(0, 7) == 0) ? 3'b100 : 3'b101,
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0,
                  int'($urandom_range(0, int'(len))), int'($urandom_range(0, 1)));
      end else begin
        axi_read(6'($urandom), 32'(line * 32), len,
                 ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01, 3'b101,
                 int'($urandom_range(0, 2)));
      end
    end

    // Reset in the middle of a four-beat write to lines 20..23.
    @(posedge clk); #1;
    awid = 6'd3; awaddr = 32'(20 * 32); awlen = 4'd3; awburst = 2'b01; awsize = 3'b101;
    awvalid = 1'b1;
    wait_hi(1, "aw_timeout");
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      d = rand256();
      send_beat(6'd3, d, 32'hFFFF_FFFF, 1'b0);
      mdl[20 + b] = d;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_bvalid", bvalid, 1'b0);
    check_eq("mid_rst_rvalid", rvalid, 1'b0);
    check_eq("mid_rst_wready", wready, 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("awready_release", awready, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("no_partial_b", bvalid, 1'b0);
    axi_read(6'd13, 32'(20 * 32), 4'd3, 2'b01, 3'b101, 2);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/bank_axi3_mem_slave.md
Name: bank_axi3_mem_slave

Overview:
- AXI3 slave memory responder: the far end of the bank BIU's AXI3 master port (AR/R/AW/W/B).
- Backs a line-granular SRAM array and serves the bank's linefill reads and eviction writebacks.
- Used as the downstream memory in bank-level simulation and FPGA bring-up.
- Independent read and write engines; one outstanding burst per direction.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 256, beat width; one beat = one array line (32 bytes).
- ID_WIDTH, 6, AXI ID width.
- DEPTH_LOG2, 10, log2 of lines in array; line index = addr[5+DEPTH_LOG2-1:5].
- RD_LAT, 4, idle cycles between AR handshake and first R beat (0 allowed).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- slv_axi3_arvalid_i / slv_axi3_arready_o  in/out  1/1  read address handshake
- slv_axi3_arid_i, slv_axi3_araddr_i, slv_axi3_arlen_i, slv_axi3_arsize_i, slv_axi3_arburst_i  in  ID_WIDTH, ADDR_WIDTH, 4, 3, 2  read address fields
- slv_axi3_rvalid_o / slv_axi3_rready_i  out/in  1/1  read data handshake
- slv_axi3_rid_o, slv_axi3_rdata_o, slv_axi3_rresp_o, slv_axi3_rlast_o  out  ID_WIDTH, DATA_WIDTH, 2, 1  read data fields
- slv_axi3_awvalid_i / slv_axi3_awready_o  in/out  1/1  write address handshake
- slv_axi3_awid_i, slv_axi3_awaddr_i, slv_axi3_awlen_i, slv_axi3_awsize_i, slv_axi3_awburst_i  in  ID_WIDTH, ADDR_WIDTH, 4, 3, 2  write address fields
- slv_axi3_wvalid_i / slv_axi3_wready_o  in/out  1/1  write data handshake
- slv_axi3_wid_i, slv_axi3_wdata_i, slv_axi3_wstrb_i, slv_axi3_wlast_i  in  ID_WIDTH, DATA_WIDTH, DATA_WIDTH/8, 1  write data fields
- slv_axi3_bvalid_o / slv_axi3_bready_i  out/in  1/1  write response handshake
- slv_axi3_bid_o, slv_axi3_bresp_o  out  ID_WIDTH, 2  write response fields

Behaviour:
- Reset (rst_i low, async):
  - Both FSMs go to IDLE.
  - All valid, last and resp outputs = 0; rid/bid/rdata = 0.
  - arready = awready = 1 once reset deasserts.
  - Array contents are not reset.
  - Reset mid-burst aborts the burst; no partial B response is generated.
- Read FSM RD_IDLE -> RD_WAIT -> RD_DATA:
  - RD_IDLE: arready=1; AR handshake latches id, line index, len, and error flag; beat count = 0.
  - Transition: to RD_WAIT if RD_LAT>0, else RD_DATA.
  - RD_WAIT: counts RD_LAT cycles, then RD_DATA. First rvalid appears exactly RD_LAT+1 cycles after the AR handshake cycle.
  - RD_DATA: rvalid=1; rdata is a register loaded from mem[line] on entry and after each non-last handshake (loaded with line+1). rdata/rresp/rlast are stable while rvalid && !rready.
  - rlast = (count == len). On handshake with rlast, return to RD_IDLE; arready re-asserts the next cycle.
- Write FSM WR_IDLE -> WR_DATA -> WR_RESP:
  - WR_IDLE: awready=1; AW handshake latches id, line, len, error flag.
  - WR_DATA: wready=1. Each W handshake writes bytes of wdata where wstrb=1 into mem[line], unless that beat is in error; then line and count increment.
  - The burst ends on the beat where count == len, regardless of wlast.
  - WR_RESP: bvalid=1, bid = latched awid, bresp = OKAY (00) or SLVERR (10). On bready, go to WR_IDLE.
- Error rules (SLVERR = 10):
  - Burst-level: burst != INCR (01), or size != 3'b101.
  - Per beat: line index >= 2^DEPTH_LOG2, i.e. any address bits above the index range are nonzero; this is evaluated per beat, so a burst can run off the end of the array.
  - Write-only: wid != latched awid, or wlast disagrees with (count == len).
  - Read error beats return rdata=0 and rresp=10; other beats of the same burst return OKAY.
  - Write errors are sticky per burst into bresp. Error beats are not written; non-error beats are.
- Concurrency:
  - Read and write engines run fully in parallel.
  - Same-line write and rdata load in the same cycle: rdata takes the pre-write value.
  - W beats arriving before AW are not accepted (wready=0 in WR_IDLE).
- Address bits [4:0] are ignored; the line is always aligned.

Test Plan:
- Write-then-read:
  - AW id=5, addr=0x40, len=0, wdata=pattern A, strb=all ones -> B id=5, resp=00.
  - Then AR id=9, addr=0x40, len=0 -> rvalid at T+5 (RD_LAT=4), rdata=A, rid=9, rlast=1.
- Partial strobe: write 0x0 all-ones, then strb=0x0000000F with new data -> read shows only bytes 0-3 updated.
- Burst with backpressure:
  - AR len=3 at 0x100; rready toggled 1,0,0,1,…
  - -> 4 beats, lines 8..11 in order, data held stable while stalled, rlast only on beat 4.
- Errors:
  - araddr=0x8000_0000 -> rdata=0, rresp=10.
  - awburst=FIXED -> bresp=10, array unchanged.
  - wid mismatch -> bresp=10.
- Concurrent and reset:
  - Simultaneous AR and AW to the same line -> read returns old data.
  - Assert rst_i mid write burst -> all valids drop immediately; awready=1 after release.
